mem_bridge: RTL
===============

# mem_bridge

Memory/IO bridge sitting directly downstream of the multi-cycle CPU core. Accepts the core's `io_*` request (mode, address, write data), decodes the address map and runs the access against the external 32-bit asynchronous SRAM or the UART register pair. It returns load data with sub-word extension and an `io_ready` completion strobe; the core's state machine holds its current state until `io_ready` is seen. UART transmit traffic is buffered in a small FIFO so `SB` to the UART completes without waiting on the serializer.

## Interface
Parameters:
- `SRAM_WAIT`, 2: cycles the SRAM strobes are held per access (≥1).
- `TX_DEPTH`, 4: UART TX FIFO entries (power of two, ≥2).

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `io_mode`  in  4  request type, `MEM_*` encoding; `MEM_NONE`=0 means no request.
- `io_addr`  in  32  byte address.
- `io_wdata`  in  32  store data, right-aligned.
- `io_rdata`  out  32  load result, registered, valid while `io_ready`=1.
- `io_ready`  out  1  one-cycle completion pulse.
- `sram_addr`  out  20  word address.
- `sram_data_o`  out  32  write data to SRAM.
- `sram_data_i`  in  32  read data from SRAM.
- `sram_data_oe`  out  1  1 = bridge drives the SRAM data bus.
- `sram_be_n`  out  4  byte enables, active-low.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  SRAM strobes, active-low.
- `uart_tx_data`  out  8  FIFO head byte.
- `uart_tx_valid`  out  1  FIFO non-empty.
- `uart_tx_ready`  in  1  serializer accepts the head byte.
- `uart_rx_data`  in  8  received byte.
- `uart_rx_valid`  in  1  received byte available.
- `uart_rx_ack`  out  1  one-cycle pulse that consumes the received byte.

## Operation
- **Modes:** `MEM_LW`, `LH`, `LHU`, `LB`, `LBU`, `SW`, `SH`, `SB`. Memory is little-endian. Lane = `addr[1:0]`. `LW`/`SW` ignore `addr[1:0]`; halfword accesses ignore `addr[0]`.
- **Address map:**
  - `0x80000000–0x803FFFFF`: SRAM; `sram_addr`=`addr[21:2]`.
  - `0xBFD003F8`: UART data. A read returns the zero-extended `uart_rx_data` and pulses `uart_rx_ack` if `uart_rx_valid`; otherwise it returns 0. A write pushes `wdata[7:0]`.
  - `0xBFD003FC`: UART status, read-only. Bit0 = TX FIFO not full, bit1 = `uart_rx_valid`, other bits 0.
  - Anything else: reads return 0, writes are dropped, completion in 1 cycle.
- **Request latch:** in IDLE, a request with mode≠NONE latches mode, addr and wdata. Later changes on the inputs are ignored until `io_ready`.
- **FSM states:** IDLE, SRAM_RD, SRAM_WR, WR_HOLD, TX_WAIT, DONE.
  - IDLE→SRAM_RD/SRAM_WR on an SRAM hit.
  - IDLE→TX_WAIT on a UART data write while the FIFO is full.
  - IDLE→DONE for all other accesses.
  - SRAM_RD: `ce_n`=`oe_n`=0 for `SRAM_WAIT` cycles. `sram_data_i` is captured on the last cycle, then →DONE.
  - SRAM_WR: `ce_n`=`we_n`=0 and `data_oe`=1 for `SRAM_WAIT` cycles. Then WR_HOLD: one cycle with `we_n`=1 and data and address still held, then →DONE.
  - TX_WAIT: stays until there is space, pushes, then →DONE.
  - DONE: `io_ready`=1 for one cycle, then →IDLE.
- **Loads:** the selected byte or halfword is sign-extended (`LB`/`LH`) or zero-extended (`LBU`/`LHU`).
- **Stores:** `sram_be_n` clears only the addressed lanes. `sram_data_o` replicates the byte or halfword onto every lane.
- **TX FIFO:** pop on `uart_tx_valid & uart_tx_ready`. A push to a full FIFO is accepted only when a pop occurs in the same cycle; otherwise it waits in TX_WAIT. Count never exceeds `TX_DEPTH`. Read and write pointers wrap modulo `TX_DEPTH`.

## Timing
- **Reset values:** `io_ready`=0, `io_rdata`=0, `sram_ce_n`=`oe_n`=`we_n`=1, `sram_be_n`=4'hF, `sram_data_oe`=0, `sram_addr`=0, `sram_data_o`=0, `uart_rx_ack`=0, FIFO empty (`uart_tx_valid`=0), state IDLE.
- **Reset mid-access:** the access is aborted, the strobes deassert immediately, and the FIFO contents are lost.
- **Latency,** counted from the cycle the request is seen in IDLE to the `io_ready` cycle:
  - SRAM read: `SRAM_WAIT`+1.
  - SRAM write: `SRAM_WAIT`+2.
  - UART, status and unmapped accesses: 1.
  - TX write into a full FIFO: 1 plus the wait cycles.
- **Request rules:** a new request may be presented in the cycle after `io_ready`. Back-to-back requests run with no extra idle cycle beyond DONE.
- **Output timing:** all SRAM outputs are registered (glitch-free strobes). `uart_rx_ack` is asserted in the DONE cycle.

## Structure
- `defs.v` holds `MEM_*` mode codes, the address-map constants (`SRAM_BASE`, `SRAM_MASK`, `UART_DATA_ADDR`, `UART_STAT_ADDR`) and the `BR_*` state encodings.
- One sub-module, `tx_fifo`: a synchronous FIFO parameterized by depth with push, pop, full, empty and head ports.

## Test plan
- Reset asserted mid-SRAM_WR → all strobes are 1 asynchronously; after release, state is IDLE and `uart_tx_valid`=0.
- `SW` 0x12345678 to 0x80000010, then `LW` with `SRAM_WAIT`=2 → write shows `be_n`=0000 and `io_ready` at cycle 4; read gets `io_rdata`=0x12345678 with `io_ready` at cycle 3.
- `SB` 0xAB to 0x80000013, then `LB` and `LBU` from the same address → `be_n`=0111, data_o=0xABABABAB; `LB` returns 0xFFFFFFAB, `LBU` returns 0x000000AB.
- `SH` 0x8001 to 0x80000002, then `LH` and `LHU` → `be_n`=0011; `LH` returns 0xFFFF8001, `LHU` returns 0x00008001.
- Five `SB` to 0xBFD003F8 with `uart_tx_ready`=0, `TX_DEPTH`=4 → the fifth stalls in TX_WAIT and the status read shows bit0=0. Raise `uart_tx_ready` for 1 cycle → the fifth completes, and bytes drain in order.
- Read 0xBFD003F8 with `uart_rx_valid`=1, `uart_rx_data`=0x5A → `io_rdata`=0x0000005A and a single `uart_rx_ack` pulse. Read 0x00000000 → 0 after 1 cycle, no strobes.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the CPU memory/IO bridge: request mode codes, address map,
// bridge FSM states and the sub-word load/store lane helpers.
package mem_bridge_pkg;

    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LW   = 4'd1;
    localparam logic [3:0] MEM_LH   = 4'd2;
    localparam logic [3:0] MEM_LHU  = 4'd3;
    localparam logic [3:0] MEM_LB   = 4'd4;
    localparam logic [3:0] MEM_LBU  = 4'd5;
    localparam logic [3:0] MEM_SW   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SB   = 4'd8;

    localparam logic [31:0] SRAM_BASE      = 32'h8000_0000;
    localparam logic [31:0] SRAM_MASK      = 32'hFFC0_0000;
    localparam logic [31:0] UART_DATA_ADDR = 32'hBFD0_03F8;
    localparam logic [31:0] UART_STAT_ADDR = 32'hBFD0_03FC;

    typedef enum logic [2:0] {
        BR_IDLE    = 3'd0,
        BR_SRAM_RD = 3'd1,
        BR_SRAM_WR = 3'd2,
        BR_WR_HOLD = 3'd3,
        BR_TX_WAIT = 3'd4,
        BR_DONE    = 3'd5
    } brState_t;

    function automatic logic isLoad(input logic [3:0] mode);
        return mode inside {MEM_LW, MEM_LH, MEM_LHU, MEM_LB, MEM_LBU};
    endfunction

    function automatic logic isStore(input logic [3:0] mode);
        return mode inside {MEM_SW, MEM_SH, MEM_SB};
    endfunction

    // Little-endian lane select followed by sign or zero extension.
    function automatic logic [31:0] loadExtend(input logic [3:0] mode, input logic [1:0] lane,
                                               input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (mode)
            MEM_LW:  res = word;
            MEM_LH:  res = {{16{h[15]}}, h};
            MEM_LHU: res = {16'h0000, h};
            MEM_LB:  res = {{24{b[7]}}, b};
            MEM_LBU: res = {24'h000000, b};
            default: res = 32'h0;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] storeBeN(input logic [3:0] mode, input logic [1:0] lane);
        logic [3:0] be;
        case (mode)
            MEM_SH:  be = lane[1] ? 4'b0011 : 4'b1100;
            MEM_SB:  be = ~(4'b0001 << lane);
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] storeData(input logic [3:0] mode, input logic [31:0] data);
        logic [31:0] res;
        case (mode)
            MEM_SH:  res = {2{data[15:0]}};
            MEM_SB:  res = {4{data[7:0]}};
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_bridge_tx_fifo.sv
// Byte FIFO buffering UART transmit traffic; a push while full is taken only
// alongside a pop in the same cycle.
module tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_pushData,
    input  logic       i_pop,
    output logic       o_full,
    output logic       o_empty,
    output logic [7:0] o_head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_rdPtr;
    logic [AW-1:0] r_wrPtr;
    logic [AW:0]   r_count;
    logic          w_doPop;
    logic          w_doPush;

    assign o_full   = (r_count == FULL_COUNT);
    assign o_empty  = (r_count == '0);
    assign o_head   = r_mem[r_rdPtr];
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_pushData;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_doPop) r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_bridge.sv
// Memory/IO bridge between the multi-cycle CPU core and the async SRAM / UART registers.
// All SRAM-facing outputs are registered from the next state so the strobes never glitch.
module mem_bridge #(
    parameter int SRAM_WAIT = 2,
    parameter int TX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  io_mode,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    output logic        io_ready,
    output logic [19:0] sram_addr,
    output logic [31:0] sram_data_o,
    input  logic [31:0] sram_data_i,
    output logic        sram_data_oe,
    output logic [3:0]  sram_be_n,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ack
);

    import mem_bridge_pkg::*;

    localparam int CW = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(SRAM_WAIT - 1);

    brState_t    r_state;
    brState_t    w_nextState;
    logic [3:0]  r_mode;
    logic [1:0]  r_lane;
    logic [7:0]  r_txByte;
    logic [CW-1:0] r_waitCnt;
    logic [31:0] r_rdata;
    logic        r_rxAck;
    logic [19:0] r_sramAddr;
    logic [31:0] r_sramDataO;
    logic        r_dataOe;
    logic [3:0]  r_beN;
    logic        r_ceN;
    logic        r_oeN;
    logic        r_weN;

    logic        w_req;
    logic        w_sramHit;
    logic        w_uartData;
    logic        w_uartStat;
    logic        w_reqLoad;
    logic        w_reqStore;
    logic        w_waitLast;
    logic        w_txFull;
    logic        w_txEmpty;
    logic        w_txPop;
    logic        w_txRoom;
    logic        w_txPush;
    logic [7:0]  w_txData;
    logic [31:0] w_immData;
    logic        w_enterSram;
    logic        w_inSram;

    assign w_req      = (r_state == BR_IDLE) && (io_mode != MEM_NONE);
    assign w_sramHit  = ((io_addr & SRAM_MASK) == SRAM_BASE);
    assign w_uartData = (io_addr == UART_DATA_ADDR);
    assign w_uartStat = (io_addr == UART_STAT_ADDR);
    assign w_reqLoad  = isLoad(io_mode);
    assign w_reqStore = isStore(io_mode);
    assign w_waitLast = (r_waitCnt == WAIT_LAST);
    assign w_txPop    = !w_txEmpty && uart_tx_ready;
    assign w_txRoom   = !w_txFull || w_txPop;
    assign w_txData   = (r_state == BR_TX_WAIT) ? r_txByte : io_wdata[7:0];

    assign w_immData = (w_reqLoad && w_uartData && uart_rx_valid) ? {24'h000000, uart_rx_data} :
                       (w_reqLoad && w_uartStat) ? {30'h0, uart_rx_valid, ~w_txFull} : 32'h0;

    assign w_enterSram = (r_state == BR_IDLE) &&
                         (w_nextState inside {BR_SRAM_RD, BR_SRAM_WR});
    assign w_inSram    = w_nextState inside {BR_SRAM_RD, BR_SRAM_WR, BR_WR_HOLD};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= BR_IDLE;
        else      r_state <= w_nextState;
    end

    // Next-state decode; the UART push is issued only when the FIFO can take it this cycle.
    always_comb begin
        w_nextState = r_state;
        w_txPush    = 1'b0;
        case (r_state)
            BR_IDLE: begin
                if (w_req) begin
                    if (w_sramHit && w_reqLoad)
                        w_nextState = BR_SRAM_RD;
                    else if (w_sramHit && w_reqStore)
                        w_nextState = BR_SRAM_WR;
                    else if (w_uartData && w_reqStore) begin
                        if (w_txRoom) begin
                            w_txPush    = 1'b1;
                            w_nextState = BR_DONE;
                        end else begin
                            w_nextState = BR_TX_WAIT;
                        end
                    end else
                        w_nextState = BR_DONE;
                end
            end
            BR_SRAM_RD: if (w_waitLast) w_nextState = BR_DONE;
            BR_SRAM_WR: if (w_waitLast) w_nextState = BR_WR_HOLD;
            BR_WR_HOLD: w_nextState = BR_DONE;
            BR_TX_WAIT: begin
                if (w_txRoom) begin
                    w_txPush    = 1'b1;
                    w_nextState = BR_DONE;
                end
            end
            BR_DONE:    w_nextState = BR_IDLE;
            default:    w_nextState = BR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode      <= MEM_NONE;
            r_lane      <= 2'b00;
            r_txByte    <= 8'h00;
            r_waitCnt   <= '0;
            r_rdata     <= 32'h0;
            r_rxAck     <= 1'b0;
            r_sramAddr  <= 20'h0;
            r_sramDataO <= 32'h0;
            r_dataOe    <= 1'b0;
            r_beN       <= 4'hF;
            r_ceN       <= 1'b1;
            r_oeN       <= 1'b1;
            r_weN       <= 1'b1;
        end else begin
            if (w_req) begin
                r_mode   <= io_mode;
                r_lane   <= io_addr[1:0];
                r_txByte <= io_wdata[7:0];
                r_rdata  <= w_immData;
            end else if (r_state == BR_SRAM_RD && w_waitLast) begin
                r_rdata <= loadExtend(r_mode, r_lane, sram_data_i);
            end

            if ((w_nextState == r_state) && (r_state inside {BR_SRAM_RD, BR_SRAM_WR}))
                r_waitCnt <= r_waitCnt + 1'b1;
            else
                r_waitCnt <= '0;

            r_rxAck  <= w_req && (w_nextState == BR_DONE) && w_reqLoad && w_uartData && uart_rx_valid;
            r_ceN    <= !w_inSram;
            r_oeN    <= (w_nextState != BR_SRAM_RD);
            r_weN    <= (w_nextState != BR_SRAM_WR);
            r_dataOe <= w_nextState inside {BR_SRAM_WR, BR_WR_HOLD};

            // Reads fetch the whole word; lane extraction happens on capture.
            if (w_enterSram) begin
                r_sramAddr <= io_addr[21:2];
                r_beN      <= (w_nextState == BR_SRAM_WR) ? storeBeN(io_mode, io_addr[1:0]) : 4'h0;
                if (w_nextState == BR_SRAM_WR) r_sramDataO <= storeData(io_mode, io_wdata);
            end else if (!w_inSram) begin
                r_beN <= 4'hF;
            end
        end
    end

    tx_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_txFifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_txPush),
        .i_pushData (w_txData),
        .i_pop      (w_txPop),
        .o_full     (w_txFull),
        .o_empty    (w_txEmpty),
        .o_head     (uart_tx_data)
    );

    assign io_rdata      = r_rdata;
    assign io_ready      = (r_state == BR_DONE);
    assign uart_rx_ack   = r_rxAck;
    assign uart_tx_valid = !w_txEmpty;
    assign sram_addr     = r_sramAddr;
    assign sram_data_o   = r_sramDataO;
    assign sram_data_oe  = r_dataOe;
    assign sram_be_n     = r_beN;
    assign sram_ce_n     = r_ceN;
    assign sram_oe_n     = r_oeN;
    assign sram_we_n     = r_weN;

endmodule
